wb_port_arbiter: RTL
====================

# wb_port_arbiter

Shares the single GPR write port between the in-order write-back stage and the out-of-band multi-cycle unit (MDU: mul/div). Grants one valid/ready requester per cycle, registers the winning write onto the register-file port, and keeps a 32-entry pending-destination scoreboard so decode can stall on reads of registers still owed by the MDU. Sits between WBU/MDU outputs and the register file; `hazard` feeds the IDU stall logic.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5, register address width (32 GPRs).
- `DATA_WIDTH`, 32, write data width.
- `STARVE_LIMIT`, 4, consecutive MDU-lost cycles before MDU is forced to win (1..7).
- `CNT_WIDTH`, 3, starvation counter width; must hold `STARVE_LIMIT`.

Ports:
- `clk` in 1 — clock, rising edge.
- `rst` in 1 — reset; one clock, asynchronous, active-high.
- `wb_valid` in 1 — WB stage has a GPR write (already qualified by its own `reg_wen`).
- `wb_ready` out 1 — WB write accepted this cycle.
- `wb_waddr` in REG_ADDR_WIDTH — WB destination.
- `wb_wdata` in DATA_WIDTH — WB data.
- `mdu_valid` in 1 — MDU result available.
- `mdu_ready` out 1 — MDU result accepted this cycle.
- `mdu_waddr` in REG_ADDR_WIDTH — MDU destination.
- `mdu_wdata` in DATA_WIDTH — MDU result.
- `issue_valid` in 1 — an MDU op is issued this cycle (marks destination pending).
- `issue_waddr` in REG_ADDR_WIDTH — destination of issued MDU op.
- `rd_addr1`, `rd_addr2` in REG_ADDR_WIDTH — decode source registers.
- `hazard` out 1 — a source register is pending.
- `rf_wen` out 1 — registered GPR write enable.
- `rf_waddr` out REG_ADDR_WIDTH — registered write address.
- `rf_wdata` out DATA_WIDTH — registered write data.
- `pending` out 32 — scoreboard state (debug/difftest).

## Operation
- Grant (combinational from valids and counter): only WB valid → WB; only MDU valid → MDU; both valid → WB, unless `starve_cnt == STARVE_LIMIT`, then MDU. Neither → no grant.
- `wb_ready = grant_wb`, `mdu_ready = grant_mdu`; never both high. Ready may depend on valid; requesters must hold valid/addr/data stable until ready.
- `starve_cnt`: +1 (saturating at `STARVE_LIMIT`) when `mdu_valid && !mdu_ready`; cleared to 0 on MDU handshake or when `mdu_valid` is low.
- Write register: on handshake, `rf_waddr/rf_wdata` <= winner's addr/data, `rf_wen` <= (addr != 0). x0 writes complete the handshake but never raise `rf_wen`. No handshake → `rf_wen` <= 0, addr/data hold.
- Scoreboard: `issue_valid && issue_waddr != 0` sets `pending[issue_waddr]`; MDU handshake clears `pending[mdu_waddr]`. Same-cycle set and clear of the same index: set wins. Set of an already-set bit: stays set. `pending[0]` always 0.
- `hazard = pending[rd_addr1] | pending[rd_addr2]`, from the registered scoreboard only; a same-cycle clear is not bypassed (one extra stall cycle, conservative).

## Timing
- Reset (async, any time): `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0, `pending`=0, `starve_cnt`=0 ⇒ `hazard`=0, `wb_ready`/`mdu_ready` follow valids combinationally. Writes in flight at reset are dropped.
- Latency: handshake in cycle N → `rf_wen` high in cycle N+1, one cycle wide per write.
- Throughput: one write per cycle; back-to-back grants to the same requester allowed.
- Starvation bound: with both valid continuously, MDU granted at the latest on cycle `STARVE_LIMIT`+1 after first assertion.
- Scoreboard: set at issue edge N visible on `hazard` in N+1; clear at handshake edge M visible in M+1.

## Configuration
- `WBARB_STARVE_EN` defined: starvation counter and forced MDU grant as above.
- Undefined: counter removed; strict WB priority (MDU granted only when `wb_valid` low). All other behaviour identical.

## Test plan
- WB only: `wb_valid`=1, addr 5, data 0x1234 → `wb_ready`=1 same cycle; next cycle `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0x1234.
- x0 write: WB addr 0, data 0xFFFF → `wb_ready`=1, next cycle `rf_wen`=0.
- Contention, STARVE_LIMIT=4, both valid held: WB granted cycles 0–3, MDU granted cycle 4 (counter 4), WB resumes cycle 5; without `WBARB_STARVE_EN`, MDU never granted while WB valid.
- Scoreboard: issue addr 7 at cycle 0; `rd_addr1`=7 → `hazard`=1 from cycle 1; MDU writes 7 at cycle 3 → `hazard`=0 from cycle 4, `rf_waddr`=7 at cycle 4.
- Same-cycle issue of 9 and MDU retire of 9 → `pending[9]`=1 afterwards.
- Async `rst` mid-stream with `pending`=0x0000_0280 and `rf_wen`=1 → immediately `pending`=0, `rf_wen`=0, `hazard`=0 without a clock edge.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// GPR write-port arbiter between write-back and the MDU, with a pending-destination scoreboard.
// Optional build macro WBARB_STARVE_EN enables the MDU starvation counter and its forced grant.
module wb_port_arbiter #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned CNT_WIDTH      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic [REG_ADDR_WIDTH-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0]     wb_wdata,
  input  logic                      mdu_valid,
  output logic                      mdu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] mdu_waddr,
  input  logic [DATA_WIDTH-1:0]     mdu_wdata,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_waddr,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr1,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr2,
  output logic                      hazard,
  output logic                      rf_wen,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic [31:0]               pending
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7 || STARVE_LIMIT >= (1 << CNT_WIDTH)) begin : g_param_check
    $error("wb_port_arbiter: STARVE_LIMIT must be 1..7 and fit in CNT_WIDTH bits");
  end

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_MDU
  } grant_e;

  grant_e                    grant;
  logic                      starve_force;
  logic [REG_ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]     sel_data;
  logic [31:0]               pending_nxt;

`ifdef WBARB_STARVE_EN
  logic [CNT_WIDTH-1:0] starve_cnt;

  assign starve_force = (starve_cnt == CNT_WIDTH'(STARVE_LIMIT));

  // Counts consecutive cycles the MDU waited; any gap or win restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!mdu_valid || mdu_ready) begin
      starve_cnt <= '0;
    end else if (!starve_force) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  always_comb begin
    grant = GNT_NONE;
    if (wb_valid && mdu_valid) begin
      grant = starve_force ? GNT_MDU : GNT_WB;
    end else if (wb_valid) begin
      grant = GNT_WB;
    end else if (mdu_valid) begin
      grant = GNT_MDU;
    end
  end

  assign wb_ready  = (grant == GNT_WB);
  assign mdu_ready = (grant == GNT_MDU);

  always_comb begin
    sel_addr = wb_waddr;
    sel_data = wb_wdata;
    if (grant == GNT_MDU) begin
      sel_addr = mdu_waddr;
      sel_data = mdu_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (grant != GNT_NONE) begin
      rf_wen   <= (sel_addr != '0);
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

  // Clear is applied before set so a same-cycle issue to the retiring index stays pending.
  always_comb begin
    pending_nxt = pending;
    if (mdu_ready) begin
      pending_nxt[mdu_waddr] = 1'b0;
    end
    if (issue_valid && issue_waddr != '0) begin
      pending_nxt[issue_waddr] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  assign hazard = pending[rd_addr1] | pending[rd_addr2];

endmodule
